// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared encodings, FSM states and width helper for wb_cache
package cache_pkg;

    localparam logic [1:0] WM_READ = 2'd0;
    localparam logic [1:0] WM_BYTE = 2'd1;
    localparam logic [1:0] WM_HALF = 2'd2;
    localparam logic [1:0] WM_WORD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL,
        S_FLUSH
    } state_e;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/wb_cache_if.sv
// rtl/wb_cache_if.sv - CPU load/store and line-wide memory signals of wb_cache
interface wb_cache_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              enable;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        write_mode;
    logic [31:0]       data_in_cpu;
    logic [31:0]       data_out;
    logic              rd_valid;
    logic              busy;
    logic              flush;
    logic              flush_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output enable, addr, write_mode, data_in_cpu, flush, mem_rdata, mem_ready,
        input  data_out, rd_valid, busy, flush_done, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  enable, addr, write_mode, data_in_cpu, flush, mem_rdata, mem_ready,
        output data_out, rd_valid, busy, flush_done, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_lane_merge.sv
// rtl/cache_lane_merge.sv - store byte-lane merge and load word extraction for one line
module cache_lane_merge
    import cache_pkg::*;
#(
    parameter int  LINE_BYTES = 16,
    localparam int OFF_W      = clog2(LINE_BYTES),
    localparam int LINE_W     = 8 * LINE_BYTES
) (
    input  logic [LINE_W-1:0] line_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [1:0]        write_mode_i,
    input  logic [31:0]       data_i,
    output logic [LINE_W-1:0] line_o,
    output logic [31:0]       rd_word_o
);

    // lane_mask drops the offset bits a half/word access ignores; the same mask
    // picks which byte of the LSB-aligned store data lands in each lane.
    always_comb begin
        int lane_mask;
        case (write_mode_i)
            WM_BYTE: lane_mask = 0;
            WM_HALF: lane_mask = 1;
            WM_WORD: lane_mask = 3;
            default: lane_mask = 0;
        endcase
        line_o = line_i;
        if (write_mode_i != WM_READ) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if ((b & ~lane_mask) == (int'(offset_i) & ~lane_mask))
                    line_o[8*b +: 8] = data_i[8*(b & lane_mask) +: 8];
            end
        end
    end

    assign rd_word_o = line_i[32*(int'(offset_i) >> 2) +: 32];

endmodule

// File: rtl/wb_cache.sv
// rtl/wb_cache.sv - direct-mapped write-back write-allocate data cache with flush
module wb_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINES      = 4,
    parameter int LINE_BYTES = 16
) (
    input  logic       clk,
    input  logic       reset,
    wb_cache_if.slave  bus
);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int OFF_W  = clog2(LINE_BYTES);
    localparam int IDX_W  = clog2(LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    state_e            state_q;
    logic [LINE_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [IDX_W-1:0]  fidx_q;
    logic [31:0]       data_out_q;
    logic              rd_valid_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic              flush_done_q;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit, idle, refill_done, store_hit, flush_step;
    logic [LINE_W-1:0] merged;
    logic [31:0]       rd_word;

    assign off         = bus.addr[OFF_W-1:0];
    assign idx         = bus.addr[OFF_W+IDX_W-1:OFF_W];
    assign tag         = bus.addr[ADDR_W-1:OFF_W+IDX_W];
    assign hit         = bus.enable && valid_q[idx] && (tag_q[idx] == tag);
    assign idle        = (state_q == S_IDLE);
    assign refill_done = (state_q == S_REFILL) && mem_req_q && bus.mem_ready;
    assign store_hit   = idle && hit && (bus.write_mode != WM_READ);
    // A flush slot ends on its write-back handshake, or at once for a clean line.
    assign flush_step  = mem_req_q ? bus.mem_ready : !dirty_q[fidx_q];

    cache_lane_merge #(.LINE_BYTES(LINE_BYTES)) u_merge (
        .line_i       (data_q[idx]),
        .offset_i     (off),
        .write_mode_i (bus.write_mode),
        .data_i       (bus.data_in_cpu),
        .line_o       (merged),
        .rd_word_o    (rd_word)
    );

    // Line storage carries no reset: its writes are qualified by state and
    // valid bits, both of which clear asynchronously.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            data_q[idx] <= bus.mem_rdata;
            tag_q[idx]  <= tag;
        end else if (store_hit) begin
            data_q[idx] <= merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            fidx_q       <= '0;
            data_out_q   <= '0;
            rd_valid_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            rd_valid_q   <= 1'b0;
            flush_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.enable) begin
                        if (hit) begin
                            if (bus.write_mode == WM_READ) begin
                                data_out_q <= rd_word;
                                rd_valid_q <= 1'b1;
                            end else begin
                                dirty_q[idx] <= 1'b1;
                            end
                        end else if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= S_WRITEBACK;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx, {OFF_W{1'b0}}};
                            mem_wdata_q <= data_q[idx];
                        end else begin
                            state_q    <= S_REFILL;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
                        end
                    end else if (bus.flush) begin
                        state_q <= S_FLUSH;
                        fidx_q  <= '0;
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ready) begin
                        state_q    <= S_REFILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
                    end
                end
                S_REFILL: begin
                    if (bus.mem_ready) begin
                        state_q      <= S_IDLE;
                        mem_req_q    <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (mem_req_q && bus.mem_ready) begin
                        mem_req_q       <= 1'b0;
                        dirty_q[fidx_q] <= 1'b0;
                    end else if (!mem_req_q && dirty_q[fidx_q]) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {tag_q[fidx_q], fidx_q, {OFF_W{1'b0}}};
                        mem_wdata_q <= data_q[fidx_q];
                    end
                    if (flush_step) begin
                        fidx_q <= fidx_q + 1'b1;
                        if (fidx_q == IDX_W'(LINES - 1)) begin
                            state_q      <= S_IDLE;
                            flush_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = !idle || (bus.enable && !hit) || (idle && bus.flush && !bus.enable);
    assign bus.data_out   = data_out_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.flush_done = flush_done_q;

endmodule

// File: tb/tb_wb_cache.sv
// tb/tb_wb_cache.sv - self-checking bench for wb_cache against a flat byte-memory model
module tb_wb_cache;
    import cache_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LINES  = 4;
    localparam int LB     = 16;
    localparam int LINE_W = 8 * LB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_cache_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();

    wb_cache #(.ADDR_W(ADDR_W), .LINES(LINES), .LINE_BYTES(LB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic              we;
        logic [31:0]       addr;
        logic [LINE_W-1:0] wdata;
    } txn_t;

    int n_cmp = 0;
    int n_mis = 0;
    int mem_lat = 3;
    txn_t txq[$];
    logic [LINE_W-1:0] backing [int unsigned];
    logic [7:0]        ref_bytes [int unsigned];
    bit                m_valid [LINES];
    bit                m_dirty [LINES];
    int unsigned       m_tag [LINES];

    function automatic logic [7:0] default_byte(input int unsigned a);
        if (a >= 32'h40 && a < 32'h50) return 8'hAA + 8'h11 * 8'((a >> 2) & 3);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    function automatic logic [7:0] ref_byte(input int unsigned a);
        if (ref_bytes.exists(a)) return ref_bytes[a];
        return default_byte(a);
    endfunction

    function automatic logic [31:0] ref_word(input int unsigned a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_byte((a & ~32'h3) + b);
        return w;
    endfunction

    function automatic logic [LINE_W-1:0] ref_line(input int unsigned la);
        logic [LINE_W-1:0] l;
        for (int b = 0; b < LB; b++) l[8*b +: 8] = ref_byte(la + b);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input int unsigned la);
        logic [LINE_W-1:0] l;
        if (backing.exists(la)) return backing[la];
        for (int b = 0; b < LB; b++) l[8*b +: 8] = default_byte(la + b);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: each handshake completes mem_lat+1 cycles after the request is seen.
    initial begin
        int wcnt;
        txn_t t;
        wcnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (!reset && bus.mem_req) begin
                if (wcnt >= mem_lat) begin
                    t.we = bus.mem_we;
                    t.addr = bus.mem_addr;
                    t.wdata = bus.mem_wdata;
                    txq.push_back(t);
                    if (bus.mem_we) backing[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem_line(bus.mem_addr);
                    bus.mem_ready = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic do_access(input logic [31:0] a, input logic [1:0] wm, input logic [31:0] d,
                             output logic [31:0] rd);
        int unsigned idx, tg, vla;
        int nb, exp_nb;
        bit hit, wb;
        logic [LINE_W-1:0] victim;
        logic [31:0] exp_rd;
        idx = (a >> 4) % LINES;
        tg = a >> 6;
        hit = m_valid[idx] && (m_tag[idx] == tg);
        wb = !hit && m_valid[idx] && m_dirty[idx];
        vla = m_tag[idx] * 64 + idx * 16;
        victim = ref_line(vla);
        exp_rd = ref_word(a);
        exp_nb = hit ? 0 : (wb ? 1 + 2 * (mem_lat + 1) : 1 + (mem_lat + 1));
        txq.delete();
        @(negedge clk);
        bus.enable = 1'b1;
        bus.addr = a;
        bus.write_mode = wm;
        bus.data_in_cpu = d;
        nb = 0;
        #1;
        while (bus.busy && nb < 200) begin
            nb++;
            @(negedge clk);
            #1;
        end
        chk("busy_cycles", nb, exp_nb);
        @(posedge clk);
        #1;
        rd = bus.data_out;
        if (wm == WM_READ) begin
            chk("rd_valid", bus.rd_valid, 1);
            chk("load_data", bus.data_out, exp_rd);
        end else begin
            chk("rd_valid_on_store", bus.rd_valid, 0);
            case (wm)
                WM_BYTE: ref_bytes[a] = d[7:0];
                WM_HALF: for (int b = 0; b < 2; b++) ref_bytes[(a & ~32'h1) + b] = d[8*b +: 8];
                default: for (int b = 0; b < 4; b++) ref_bytes[(a & ~32'h3) + b] = d[8*b +: 8];
            endcase
        end
        bus.enable = 1'b0;
        chk("txn_count", txq.size(), hit ? 0 : (wb ? 2 : 1));
        if (wb && txq.size() == 2) begin
            chk("wb_we", txq[0].we, 1);
            chk("wb_addr", txq[0].addr, vla);
            chk("wb_data", txq[0].wdata, victim);
        end
        if (!hit && txq.size() >= 1) begin
            chk("refill_we", txq[txq.size()-1].we, 0);
            chk("refill_addr", txq[txq.size()-1].addr, a & ~32'hF);
        end
        m_dirty[idx] = (hit && m_dirty[idx]) || (wm != WM_READ);
        m_valid[idx] = 1'b1;
        m_tag[idx] = tg;
    endtask

    task automatic do_flush();
        txn_t exp_q[$];
        txn_t e;
        int pulses, waited, after;
        for (int i = 0; i < LINES; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                e.we = 1'b1;
                e.addr = m_tag[i] * 64 + i * 16;
                e.wdata = ref_line(e.addr);
                exp_q.push_back(e);
            end
        end
        txq.delete();
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        pulses = 0;
        waited = 0;
        after = 0;
        while (waited < 300 && after < 3) begin
            @(posedge clk);
            #1;
            waited++;
            if (bus.flush_done) pulses++;
            if (pulses > 0) after++;
        end
        chk("flush_done_pulses", pulses, 1);
        chk("flush_wb_count", txq.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < txq.size(); k++) begin
            chk("flush_wb_addr", txq[k].addr, exp_q[k].addr);
            chk("flush_wb_data", txq[k].wdata, exp_q[k].wdata);
        end
        for (int i = 0; i < LINES; i++) m_dirty[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.flush = 1'b0;
        bus.addr = '0;
        bus.write_mode = WM_READ;
        bus.data_in_cpu = '0;
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_flush_done", bus.flush_done, 0);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b0;

        mem_lat = 3;
        do_access(32'h40, WM_READ, 0, rd);
        chk("cold_read_word", rd, 32'hAAAAAAAA);
        do_access(32'h43, WM_BYTE, 32'h5A, rd);
        do_access(32'h40, WM_READ, 0, rd);
        chk("byte_merge_word", rd, 32'h5AAAAAAA);
        do_access(32'h80, WM_READ, 0, rd);
        chk("evict_txns", txq.size(), 2);
        if (txq.size() == 2) begin
            chk("evict_wb_addr", txq[0].addr, 32'h40);
            chk("evict_refill_addr", txq[1].addr, 32'h80);
        end
        do_access(32'h47, WM_HALF, 32'h1234, rd);
        do_access(32'h44, WM_READ, 0, rd);
        chk("half_upper", rd[31:16], 16'h1234);

        do_flush();
        do_access(32'h50, WM_WORD, 32'hCAFE_F00D, rd);
        do_access(32'h73, WM_BYTE, 32'h77, rd);
        do_flush();
        chk("flush_two_wb", txq.size(), 2);
        if (txq.size() == 2) begin
            chk("flush_first_idx1", txq[0].addr, 32'h50);
            chk("flush_second_idx3", txq[1].addr, 32'h70);
        end
        do_access(32'h50, WM_READ, 0, rd);
        chk("post_flush_hit", txq.size(), 0);

        mem_lat = 20;
        txq.delete();
        @(negedge clk);
        bus.enable = 1'b1;
        bus.addr = 32'h60;
        bus.write_mode = WM_READ;
        repeat (3) @(negedge clk);
        #1;
        chk("refill_pending", bus.mem_req, 1);
        reset = 1'b1;
        #1;
        chk("rst_async_mem_req", bus.mem_req, 0);
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        mem_lat = 2;
        do_access(32'h60, WM_READ, 0, rd);
        chk("rst_refetch", txq.size(), 1);

        for (int n = 0; n < 80; n++) begin
            mem_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) do_flush();
            do_access(32'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), $urandom, rd);
        end
        do_flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
